// File: rtl/pc_branch_ctrl_pkg.sv
// Shared definitions for the PC sequencer: condition codes, FSM encoding
// and the condition evaluator used against the {Z,V,N} flag vector.
package pc_branch_ctrl_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_WAIT_FLAGS = 2'b01,
        ST_HALT       = 2'b10
    } state_e;

    // flags = {Z, V, N}
    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic met;
        z = flags[2];
        v = flags[1];
        n = flags[0];
        met = 1'b0;
        unique case (cond)
            COND_NEQ:    met = !z;
            COND_EQ:     met = z;
            COND_GT:     met = !z && !n;
            COND_LT:     met = n;
            COND_GTE:    met = z || !n;
            COND_LTE:    met = z || n;
            COND_OVFL:   met = v;
            COND_UNCOND: met = 1'b1;
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/pc_branch_ctrl_adder.sv
// Ripple-carry adder used for both the +2 sequential step and the branch
// target; the carry out of the top bit is dropped (modulo 2^WIDTH).
module full_adder_1bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module branch_target_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);
    logic [WIDTH-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar i;
    for (i = 0; i < WIDTH - 1; i++) begin : g_fa
        full_adder_1bit u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    // Top bit needs only the sum; its carry would leave the PC range anyway.
    assign o_sum[WIDTH-1] = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_carry[WIDTH-1];
endmodule

// File: rtl/pc_branch_ctrl.sv
// PC sequencer and branch resolver: owns the fetch PC, resolves B/BR against
// the {Z,V,N} flags, parks branches whose flags are not yet current, and halts.
module pc_branch_ctrl
    import pc_branch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               IMM_W    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic             br_reg_i,
    input  logic [2:0]       br_cond_i,
    input  logic [IMM_W-1:0] br_imm_i,
    input  logic [WIDTH-1:0] br_reg_val_i,
    input  logic [2:0]       flags_i,
    input  logic             flags_valid_i,
    input  logic             halt_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus2_o,
    output logic             flush_o,
    output logic             taken_o,
    output logic             halted_o,
    output logic [1:0]       dbg_state_o
);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

    state_e           r_state;
    state_e           w_next_state;

    logic [WIDTH-1:0] r_pc;
    logic             r_halted;
    logic [2:0]       r_cond;
    logic             r_reg;
    logic [IMM_W-1:0] r_imm;
    logic [WIDTH-1:0] r_reg_val;

    logic             w_in_wait;
    logic [2:0]       w_sel_cond;
    logic             w_sel_reg;
    logic [IMM_W-1:0] w_sel_imm;
    logic [WIDTH-1:0] w_sel_reg_val;
    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_pc_plus2;
    logic [WIDTH-1:0] w_b_target;
    logic [WIDTH-1:0] w_target;
    logic             w_cond_true;

    logic             w_run_go;
    logic             w_halt_req;
    logic             w_park;
    logic             w_resolve;
    logic             w_seq;
    logic             w_take;

    logic [WIDTH-1:0] w_pc_next;
    logic             w_flush;
    logic             w_taken;

    // A parked branch resolves from its latched fields; otherwise decode drives.
    assign w_in_wait     = (r_state == ST_WAIT_FLAGS);
    assign w_sel_cond    = w_in_wait ? r_cond    : br_cond_i;
    assign w_sel_reg     = w_in_wait ? r_reg     : br_reg_i;
    assign w_sel_imm     = w_in_wait ? r_imm     : br_imm_i;
    assign w_sel_reg_val = w_in_wait ? r_reg_val : br_reg_val_i;

    assign w_offset = {{(WIDTH-IMM_W-1){w_sel_imm[IMM_W-1]}}, w_sel_imm, 1'b0};

    branch_target_adder #(.WIDTH(WIDTH)) u_step_adder (
        .i_a   (r_pc),
        .i_b   (PC_STEP),
        .o_sum (w_pc_plus2)
    );

    branch_target_adder #(.WIDTH(WIDTH)) u_target_adder (
        .i_a   (w_pc_plus2),
        .i_b   (w_offset),
        .o_sum (w_b_target)
    );

    assign w_target    = w_sel_reg ? (w_sel_reg_val & ~WIDTH'(1)) : w_b_target;
    assign w_cond_true = cond_met(w_sel_cond, flags_i);

    // br_valid_i is only consumed in RUN when decode is not stalling us.
    assign w_run_go   = (r_state == ST_RUN) && !stall_i;
    assign w_halt_req = w_run_go && halt_i;
    assign w_park     = w_run_go && !halt_i && br_valid_i && !flags_valid_i
                        && (br_cond_i != COND_UNCOND);
    assign w_resolve  = (w_run_go && !halt_i && br_valid_i && !w_park)
                        || (w_in_wait && flags_valid_i);
    assign w_seq      = w_run_go && !halt_i && !br_valid_i;
    assign w_take     = w_resolve && w_cond_true;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_halt_req) begin
                    w_next_state = ST_HALT;
                end else if (w_park) begin
                    w_next_state = ST_WAIT_FLAGS;
                end
            end
            ST_WAIT_FLAGS: begin
                if (flags_valid_i) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        w_flush   = 1'b0;
        w_taken   = 1'b0;
        if (w_take) begin
            w_pc_next = w_target;
            w_flush   = 1'b1;
            w_taken   = 1'b1;
        end else if (w_resolve || w_seq) begin
            w_pc_next = w_pc_plus2;
        end else if (w_park) begin
            w_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_halted  <= 1'b0;
            r_cond    <= '0;
            r_reg     <= 1'b0;
            r_imm     <= '0;
            r_reg_val <= '0;
        end else begin
            r_pc     <= w_pc_next;
            r_halted <= (w_next_state == ST_HALT);
            if (w_park) begin
                r_cond    <= br_cond_i;
                r_reg     <= br_reg_i;
                r_imm     <= br_imm_i;
                r_reg_val <= br_reg_val_i;
            end
        end
    end

    assign pc_o        = r_pc;
    assign pc_plus2_o  = w_pc_plus2;
    assign flush_o     = w_flush & rst_n;
    assign taken_o     = w_taken & rst_n;
    assign halted_o    = r_halted;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed and randomized checks of pc_branch_ctrl against a behavioural
// model of the PC sequencing and branch rules.
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_valid_i = 1'b0;
    logic        br_reg_i = 1'b0;
    logic [2:0]  br_cond_i = 3'b000;
    logic [8:0]  br_imm_i = 9'h000;
    logic [15:0] br_reg_val_i = 16'h0000;
    logic [2:0]  flags_i = 3'b000;
    logic        flags_valid_i = 1'b1;
    logic        halt_i = 1'b0;
    logic [15:0] pc_o;
    logic [15:0] pc_plus2_o;
    logic        flush_o;
    logic        taken_o;
    logic        halted_o;
    logic [1:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q[$];

    // behavioural model state
    int   m_pc = 0;
    bit   m_halted = 1'b0;
    bit   m_wait = 1'b0;
    logic [2:0] m_cond = 3'b000;
    bit   m_reg = 1'b0;
    int   m_imm = 0;
    int   m_val = 0;
    int   m_next_pc = 0;
    bit   m_next_halted = 1'b0;
    bit   m_next_wait = 1'b0;
    bit   e_flush = 1'b0;
    bit   e_taken = 1'b0;

    logic        obs_flush;
    logic        obs_taken;
    logic [15:0] obs_pc;
    logic [15:0] obs_plus2;
    logic        obs_halted;

    always #5 clk = ~clk;

    pc_branch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .br_valid_i    (br_valid_i),
        .br_reg_i      (br_reg_i),
        .br_cond_i     (br_cond_i),
        .br_imm_i      (br_imm_i),
        .br_reg_val_i  (br_reg_val_i),
        .flags_i       (flags_i),
        .flags_valid_i (flags_valid_i),
        .halt_i        (halt_i),
        .pc_o          (pc_o),
        .pc_plus2_o    (pc_plus2_o),
        .flush_o       (flush_o),
        .taken_o       (taken_o),
        .halted_o      (halted_o),
        .dbg_state_o   (dbg_state_o)
    );

    function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
        bit z;
        bit v;
        bit n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_resolve(input logic [2:0] c, input bit r, input int imm, input int val);
        if (cond_true(c, flags_i)) begin
            e_taken = 1'b1;
            e_flush = 1'b1;
            m_next_pc = r ? (val & 'hFFFE) : ((m_pc + 2 + 2 * imm) & 'hFFFF);
        end else begin
            m_next_pc = (m_pc + 2) & 'hFFFF;
        end
    endtask

    task automatic model_eval();
        e_flush = 1'b0;
        e_taken = 1'b0;
        m_next_pc = m_pc;
        m_next_halted = m_halted;
        m_next_wait = m_wait;
        if (!rst_n) begin
            m_next_pc = 0;
            m_next_halted = 1'b0;
            m_next_wait = 1'b0;
        end else if (m_halted) begin
            m_next_pc = m_pc;
        end else if (m_wait) begin
            if (flags_valid_i) begin
                model_resolve(m_cond, m_reg, m_imm, m_val);
                m_next_wait = 1'b0;
            end
        end else if (stall_i) begin
            m_next_pc = m_pc;
        end else if (halt_i) begin
            m_next_halted = 1'b1;
        end else if (br_valid_i && !flags_valid_i && br_cond_i != 3'b111) begin
            e_flush = 1'b1;
            m_next_wait = 1'b1;
            m_cond = br_cond_i;
            m_reg = br_reg_i;
            m_imm = int'($signed(br_imm_i));
            m_val = int'(br_reg_val_i);
        end else if (br_valid_i) begin
            model_resolve(br_cond_i, br_reg_i, int'($signed(br_imm_i)), int'(br_reg_val_i));
        end else begin
            m_next_pc = (m_pc + 2) & 'hFFFF;
        end
    endtask

    // One clock: sample combinational outputs mid-cycle, then registered ones after the edge.
    task automatic step();
        #1;
        obs_flush = flush_o;
        obs_taken = taken_o;
        model_eval();
        @(posedge clk);
        #1;
        m_pc = m_next_pc;
        m_halted = m_next_halted;
        m_wait = m_next_wait;
        obs_pc = pc_o;
        obs_plus2 = pc_plus2_o;
        obs_halted = halted_o;
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0;
        br_valid_i = 1'b0;
        br_reg_i = 1'b0;
        br_cond_i = 3'b000;
        br_imm_i = 9'h000;
        br_reg_val_i = 16'h0000;
        flags_i = 3'b000;
        flags_valid_i = 1'b1;
        halt_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic advance(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        n_tests++;
        if (obs_pc !== 16'h0000) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 0000", obs_pc);
        end
        n_tests++;
        if (obs_halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted: got %b expected 0", obs_halted);
        end
        n_tests++;
        if (obs_plus2 !== 16'h0002) begin
            n_fail++; $display("FAIL reset_plus2: got %h expected 0002", obs_plus2);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_tests++;
            if (obs_pc !== 16'(2 * i) || obs_flush !== 1'b0 || obs_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run[%0d]: got pc=%h flush=%b taken=%b expected pc=%h flush=0 taken=0",
                         i, obs_pc, obs_flush, obs_taken, 16'(2 * i));
            end
        end
    endtask

    task automatic test_b_taken();
        do_reset();
        advance(8);
        n_tests++;
        if (obs_pc !== 16'h0010) begin
            n_fail++; $display("FAIL b_taken_setup: got %h expected 0010", obs_pc);
        end
        br_valid_i = 1'b1; br_reg_i = 1'b0; br_cond_i = 3'b001;
        br_imm_i = 9'd5; flags_i = 3'b100; flags_valid_i = 1'b1;
        step();
        n_tests++;
        if (obs_taken !== 1'b1 || obs_flush !== 1'b1 || obs_pc !== 16'h001C) begin
            n_fail++;
            $display("FAIL b_eq_taken: got taken=%b flush=%b pc=%h expected taken=1 flush=1 pc=001c",
                     obs_taken, obs_flush, obs_pc);
        end
        idle_inputs();
    endtask

    task automatic test_b_not_taken();
        do_reset();
        advance(8);
        br_valid_i = 1'b1; br_reg_i = 1'b0; br_cond_i = 3'b011;
        br_imm_i = 9'd5; flags_i = 3'b000; flags_valid_i = 1'b1;
        step();
        n_tests++;
        if (obs_taken !== 1'b0 || obs_flush !== 1'b0 || obs_pc !== 16'h0012) begin
            n_fail++;
            $display("FAIL b_lt_not_taken: got taken=%b flush=%b pc=%h expected taken=0 flush=0 pc=0012",
                     obs_taken, obs_flush, obs_pc);
        end
        br_cond_i = 3'b111; br_imm_i = 9'h1F7;
        step();
        n_tests++;
        if (obs_taken !== 1'b1 || obs_pc !== 16'h0002) begin
            n_fail++;
            $display("FAIL b_back_neg9: got taken=%b pc=%h expected taken=1 pc=0002", obs_taken, obs_pc);
        end
        idle_inputs();
    endtask

    task automatic test_br_and_wrap();
        do_reset();
        br_valid_i = 1'b1; br_reg_i = 1'b1; br_cond_i = 3'b111; br_reg_val_i = 16'hABCD;
        step();
        n_tests++;
        if (obs_taken !== 1'b1 || obs_pc !== 16'hABCC) begin
            n_fail++; $display("FAIL br_uncond: got taken=%b pc=%h expected taken=1 pc=abcc", obs_taken, obs_pc);
        end
        br_reg_val_i = 16'hFFFF;
        step();
        n_tests++;
        if (obs_pc !== 16'hFFFE || obs_plus2 !== 16'h0000) begin
            n_fail++; $display("FAIL br_to_fffe: got pc=%h plus2=%h expected pc=fffe plus2=0000", obs_pc, obs_plus2);
        end
        br_reg_i = 1'b0; br_imm_i = 9'h000;
        step();
        n_tests++;
        if (obs_taken !== 1'b1 || obs_pc !== 16'h0000) begin
            n_fail++; $display("FAIL b_wrap: got taken=%b pc=%h expected taken=1 pc=0000", obs_taken, obs_pc);
        end
        idle_inputs();
    endtask

    task automatic test_wait_flags();
        do_reset();
        advance(4);
        br_valid_i = 1'b1; br_reg_i = 1'b0; br_cond_i = 3'b110;
        br_imm_i = 9'd3; flags_i = 3'b000; flags_valid_i = 1'b0;
        step();
        n_tests++;
        if (obs_flush !== 1'b1 || obs_taken !== 1'b0 || obs_pc !== 16'h0008) begin
            n_fail++;
            $display("FAIL wait_entry: got flush=%b taken=%b pc=%h expected flush=1 taken=0 pc=0008",
                     obs_flush, obs_taken, obs_pc);
        end
        br_valid_i = 1'b0; br_imm_i = 9'd100; halt_i = 1'b1; stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (obs_flush !== 1'b0 || obs_pc !== 16'h0008 || obs_halted !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: got flush=%b pc=%h halted=%b expected flush=0 pc=0008 halted=0",
                         i, obs_flush, obs_pc, obs_halted);
            end
        end
        halt_i = 1'b0; flags_valid_i = 1'b1; flags_i = 3'b010;
        step();
        n_tests++;
        if (obs_taken !== 1'b1 || obs_flush !== 1'b1 || obs_pc !== 16'h0010) begin
            n_fail++;
            $display("FAIL wait_resolve: got taken=%b flush=%b pc=%h expected taken=1 flush=1 pc=0010",
                     obs_taken, obs_flush, obs_pc);
        end
        idle_inputs();
        step();
        n_tests++;
        if (obs_pc !== 16'h0012 || obs_halted !== 1'b0) begin
            n_fail++; $display("FAIL wait_after: got pc=%h halted=%b expected pc=0012 halted=0", obs_pc, obs_halted);
        end
    endtask

    task automatic test_stall();
        do_reset();
        advance(2);
        stall_i = 1'b1; br_valid_i = 1'b1; br_cond_i = 3'b111; br_imm_i = 9'd20;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if (obs_pc !== 16'h0004 || obs_taken !== 1'b0 || obs_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got pc=%h taken=%b flush=%b expected pc=0004 taken=0 flush=0",
                         i, obs_pc, obs_taken, obs_flush);
            end
        end
        stall_i = 1'b0;
        step();
        n_tests++;
        if (obs_pc !== 16'h002E || obs_taken !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got pc=%h taken=%b expected pc=002e taken=1", obs_pc, obs_taken);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        advance(16);
        halt_i = 1'b1;
        step();
        n_tests++;
        if (obs_halted !== 1'b1 || obs_pc !== 16'h0020) begin
            n_fail++; $display("FAIL halt_entry: got halted=%b pc=%h expected halted=1 pc=0020", obs_halted, obs_pc);
        end
        halt_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            br_valid_i = 1'($urandom_range(0, 1));
            br_cond_i = 3'b111;
            br_imm_i = 9'($urandom_range(0, 511));
            step();
            n_tests++;
            if (obs_pc !== 16'h0020 || obs_halted !== 1'b1 || obs_flush !== 1'b0 || obs_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got pc=%h halted=%b flush=%b taken=%b expected pc=0020 halted=1 flush=0 taken=0",
                         i, obs_pc, obs_halted, obs_flush, obs_taken);
            end
        end
        do_reset();
        n_tests++;
        if (obs_pc !== 16'h0000 || obs_halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: got pc=%h halted=%b expected pc=0000 halted=0", obs_pc, obs_halted);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) == 0 || (m_halted && $urandom_range(0, 3) == 0)) ? 1'b0 : 1'b1;
            stall_i = ($urandom_range(0, 7) == 0);
            br_valid_i = ($urandom_range(0, 2) == 0);
            br_reg_i = 1'($urandom_range(0, 1));
            br_cond_i = 3'($urandom_range(0, 7));
            br_imm_i = 9'($urandom_range(0, 511));
            br_reg_val_i = 16'($urandom_range(0, 65535));
            flags_i = 3'($urandom_range(0, 7));
            flags_valid_i = ($urandom_range(0, 3) != 0);
            halt_i = ($urandom_range(0, 39) == 0);
            step();
            exp_q.push_back(16'(m_pc));
            n_tests++;
            if (obs_flush !== e_flush || obs_taken !== e_taken) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got flush=%b taken=%b expected flush=%b taken=%b",
                         i, obs_flush, obs_taken, e_flush, e_taken);
            end
            exp_pc = exp_q.pop_front();
            n_tests++;
            if (obs_pc !== exp_pc || obs_plus2 !== exp_pc + 16'd2) begin
                n_fail++;
                $display("FAIL rand_pc[%0d]: got pc=%h plus2=%h expected pc=%h plus2=%h",
                         i, obs_pc, obs_plus2, exp_pc, exp_pc + 16'd2);
            end
            n_tests++;
            if (obs_halted !== m_halted) begin
                n_fail++; $display("FAIL rand_halted[%0d]: got %b expected %b", i, obs_halted, m_halted);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_b_taken();
        test_b_not_taken();
        test_br_and_wrap();
        test_wait_flags();
        test_stall();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
